// File: rtl/ddma_flit_sender.sv
// ddma_flit_sender
//   Read-side DDMA engine. A command (start word address, flit count) makes
//   the engine read that many consecutive memory words and stream them
//   verbatim as flits into the router local port. Words are prefetched into
//   a small FIFO so that a stalled router never loses data.
//
//   Optional feature: define DDMA_CMD_PENDING_EN to add a one-entry pending
//   command register that queues a command arriving while busy.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears all control state
//   cmd_in         start pulse, qualifies addr_in / nbytes_in
//   addr_in        start word address
//   nbytes_in      number of flits (words) to send
//   status_out     busy
//   done_out       one-cycle completion pulse
//   err_out        one-cycle pulse: a command was dropped
//   mem_enable_out memory read strobe
//   mem_addr_out   memory read word address
//   mem_data_in    read data, valid the cycle after the strobe
//   tx_out         flit valid towards router
//   data_out       flit towards router
//   credit_in      router accepts the flit this cycle
module ddma_flit_sender #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int COUNT_WIDTH      = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_in,
  input  logic [ADDR_WIDTH-1:0]       addr_in,
  input  logic [COUNT_WIDTH-1:0]      nbytes_in,
  output logic                        status_out,
  output logic                        done_out,
  output logic                        err_out,
  output logic                        mem_enable_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
  output logic                        tx_out,
  output logic [FLIT_WIDTH-1:0]       data_out,
  input  logic                        credit_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                   state;
  logic [COUNT_WIDTH-1:0]   left;
  logic                     rd_vld_p1;
  logic [FLIT_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wptr;
  logic [PTR_W-1:0]         rptr;
  logic [CNT_W-1:0]         count;
  logic                     pend_vld;
  logic [ADDR_WIDTH-1:0]    pend_addr;
  logic [COUNT_WIDTH-1:0]   pend_len;

  logic                     xfer;
  logic [CNT_W-1:0]         count_nxt;
  logic                     space;
  logic                     start;
  logic [ADDR_WIDTH-1:0]    start_addr;
  logic [COUNT_WIDTH-1:0]   start_len;
  logic                     take_cmd;
  logic                     latch;
  logic                     drop;

  // Router side: when the FIFO is empty, returning read data bypasses it so
  // the first flit is presented the same cycle it comes back from memory.
  // If it is not accepted it is also pushed, so the head shows the same word.
  assign tx_out   = (count != '0) || rd_vld_p1;
  assign data_out = (count != '0) ? fifo_mem[rptr] :
                    (rd_vld_p1 ? mem_data_in : '0);
  assign xfer     = tx_out && credit_in;

  assign count_nxt = count + CNT_W'(rd_vld_p1) - CNT_W'(xfer);
  // Reserve a slot for the read in flight as well as the one being issued.
  assign space     = (count_nxt + CNT_W'(mem_enable_out)) < CNT_W'(FIFO_DEPTH);

  always_comb begin
    start      = 1'b0;
    start_addr = addr_in;
    start_len  = nbytes_in;
    take_cmd   = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        start    = cmd_in;
        take_cmd = cmd_in;
      end
      DONE: begin
        if (pend_vld) begin
          start      = 1'b1;
          start_addr = pend_addr;
          start_len  = pend_len;
        end
`ifdef DDMA_CMD_PENDING_EN
        // A command in the done cycle would be queued and started next
        // cycle anyway, so it is started directly.
        else if (cmd_in) begin
          start    = 1'b1;
          take_cmd = 1'b1;
        end
`endif
      end
      default: ;
    endcase
`ifdef DDMA_CMD_PENDING_EN
    latch = cmd_in && status_out && !pend_vld && !take_cmd;
`endif
    drop = cmd_in && status_out && !take_cmd && !latch;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      left           <= '0;
      rd_vld_p1      <= 1'b0;
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      pend_vld       <= 1'b0;
      status_out     <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
      mem_enable_out <= 1'b0;
      mem_addr_out   <= '0;
    end else begin
      // stage p0 -> p1: read strobe becomes read-data valid
      rd_vld_p1      <= mem_enable_out;
      count          <= count_nxt;
      if (rd_vld_p1) wptr <= wptr + PTR_W'(1);
      if (xfer)      rptr <= rptr + PTR_W'(1);
      done_out       <= 1'b0;
      err_out        <= drop;
      mem_enable_out <= 1'b0;
      if (latch) pend_vld <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) pend_vld <= 1'b0;
          if (start) begin
            status_out <= 1'b1;
            if (start_len == '0) begin
              state    <= DONE;
              done_out <= 1'b1;
            end else begin
              state          <= FETCH;
              mem_enable_out <= 1'b1;
              mem_addr_out   <= start_addr;
              left           <= start_len - COUNT_WIDTH'(1);
            end
          end else begin
            state      <= IDLE;
            status_out <= 1'b0;
          end
        end
        FETCH: begin
          if (left == '0) begin
            state <= DRAIN;
          end else if (space) begin
            mem_enable_out <= 1'b1;
            mem_addr_out   <= mem_addr_out + ADDR_WIDTH'(1);
            left           <= left - COUNT_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            state    <= DONE;
            done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stage p1: returning data is captured into the FIFO storage
  always_ff @(posedge clock) begin
    if (rd_vld_p1) fifo_mem[wptr] <= mem_data_in;
  end

  always_ff @(posedge clock) begin
    if (latch) begin
      pend_addr <= addr_in;
      pend_len  <= nbytes_in;
    end
  end

endmodule

// File: tb/tb_ddma_flit_sender.sv
module tb_ddma_flit_sender;
  localparam int AW = 16;
  localparam int FW = 32;
  localparam int CW = 16;
`ifdef DDMA_CMD_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_in = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [CW-1:0] nbytes_in = '0;
  logic          status_out, done_out, err_out, mem_enable_out, tx_out;
  logic [AW-1:0] mem_addr_out;
  logic [FW-1:0] mem_data_in = '0;
  logic [FW-1:0] data_out;
  logic          credit_in = 1'b1;

  always #5 clock = ~clock;

  ddma_flit_sender dut (
    .clock(clock), .reset(reset), .cmd_in(cmd_in), .addr_in(addr_in),
    .nbytes_in(nbytes_in), .status_out(status_out), .done_out(done_out),
    .err_out(err_out), .mem_enable_out(mem_enable_out),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in), .tx_out(tx_out),
    .data_out(data_out), .credit_in(credit_in)
  );

  logic [FW-1:0] bmem [0:65535];
  logic [FW-1:0] exp_flit [$];
  logic [AW-1:0] exp_addr [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cmode = 0;
  int cmd_cyc = 0, first_tx = -1, first_rd = -1, last_hs = 0, done_cyc = 0;
  int hs_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, st_rise = 0;
  int extra_rd = 0, extra_flit = 0;
  logic          stall_prev = 1'b0;
  logic [FW-1:0] stall_data = '0;
  logic          prev_status = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory answers one cycle after the strobe; otherwise the bus carries junk.
  always @(posedge clock) begin
    mem_data_in <= mem_enable_out ? bmem[mem_addr_out] : $urandom;
    cyc = cyc + 1;
  end

  always @(posedge clock) begin
    #1;
    case (cmode)
      0: credit_in = 1'b1;
      1: credit_in = ~credit_in;
      default: credit_in = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock) begin
    if (reset) begin
      stall_prev  = 1'b0;
      prev_status = 1'b0;
    end else begin
      if (cmd_in) begin
        cmd_cyc  = cyc;
        first_tx = -1;
        first_rd = -1;
      end
      if (stall_prev) begin
        chk("hold_tx", 32'(tx_out), 32'd1);
        chk("hold_data", data_out, stall_data);
      end
      stall_prev = tx_out && !credit_in;
      stall_data = data_out;
      if (mem_enable_out) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr.size() > 0) chk("rd_addr", 32'(mem_addr_out), 32'(exp_addr.pop_front()));
        else extra_rd++;
      end
      if (tx_out && first_tx < 0) first_tx = cyc;
      if (tx_out && credit_in) begin
        hs_cnt++;
        last_hs = cyc;
        if (exp_flit.size() > 0) chk("flit", data_out, exp_flit.pop_front());
        else extra_flit++;
      end
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err_out) err_cnt++;
      if (status_out && !prev_status) st_rise++;
      prev_status = status_out;
    end
  end

  task automatic expect_cmd(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ad;
    ad = a;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ad);
      exp_flit.push_back(bmem[ad]);
      ad = ad + 1'b1;
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input int n);
    @(posedge clock);
    #1;
    cmd_in    = 1'b1;
    addr_in   = a;
    nbytes_in = CW'(n);
    @(posedge clock);
    #1;
    cmd_in = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k;
    k = 0;
    while (hs_cnt < target && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("hs_reached", 32'(hs_cnt >= target), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
    #1;
    chk("leftover_flits", 32'(exp_flit.size()), 32'd0);
    chk("leftover_reads", 32'(exp_addr.size()), 32'd0);
    chk("status_idle", 32'(status_out), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_status"}, 32'(status_out), 32'd0);
    chk({tag, "_done"}, 32'(done_out), 32'd0);
    chk({tag, "_err"}, 32'(err_out), 32'd0);
    chk({tag, "_men"}, 32'(mem_enable_out), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr_out), 32'd0);
    chk({tag, "_tx"}, 32'(tx_out), 32'd0);
    chk({tag, "_data"}, data_out, 32'd0);
  endtask

  int b_hs, b_rd, b_done, b_err, b_rise;
  task automatic snap();
    b_hs = hs_cnt; b_rd = rd_cnt; b_done = done_cnt; b_err = err_cnt; b_rise = st_rise;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) bmem[i] = $urandom;
    bmem[0] = 32'h0000_0101;
    bmem[1] = 32'd14;

    // Reset state
    repeat (2) @(negedge clock);
    chk_reset_vals("rst");
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1 chk_reset_vals("post_rst");

    // 16-flit transfer, credit always on: latency and throughput
    cmode = 0;
    snap();
    expect_cmd(16'h0000, 16);
    send_cmd(16'h0000, 16);
    wait_dones(b_done + 1, 200);
    chk("t1_first_rd", 32'(first_rd - cmd_cyc), 32'd1);
    chk("t1_first_tx", 32'(first_tx - cmd_cyc), 32'd2);
    chk("t1_last_hs", 32'(last_hs - cmd_cyc), 32'd17);
    chk("t1_done", 32'(done_cyc - cmd_cyc), 32'd18);
    chk("t1_busy_at_done", 32'(status_out), 32'd1);
    @(negedge clock);
    #1 chk("t1_idle_after", 32'(status_out), 32'd0);
    chk("t1_flits", 32'(hs_cnt - b_hs), 32'd16);
    settle();

    // Same transfer with credit toggling every cycle
    cmode = 1;
    snap();
    expect_cmd(16'h0000, 16);
    send_cmd(16'h0000, 16);
    wait_dones(b_done + 1, 300);
    chk("t2_done_after_last", 32'(done_cyc > last_hs), 32'd1);
    chk("t2_flits", 32'(hs_cnt - b_hs), 32'd16);
    chk("t2_reads", 32'(rd_cnt - b_rd), 32'd16);
    settle();
    cmode = 0;

    // Zero length
    snap();
    send_cmd(16'h0040, 0);
    wait_dones(b_done + 1, 50);
    chk("t3_done", 32'(done_cyc - cmd_cyc), 32'd1);
    settle();
    chk("t3_reads", 32'(rd_cnt - b_rd), 32'd0);
    chk("t3_no_tx", 32'(first_tx), 32'hFFFF_FFFF);

    // Address wrap
    snap();
    expect_cmd(16'hFFFE, 4);
    send_cmd(16'hFFFE, 4);
    wait_dones(b_done + 1, 100);
    chk("t4_flits", 32'(hs_cnt - b_hs), 32'd4);
    settle();

    // Second command during a transfer
    snap();
    expect_cmd(16'h0000, 16);
    send_cmd(16'h0000, 16);
    wait_hs(b_hs + 5, 100);
    if (PEND) expect_cmd(16'h0010, 8);
    send_cmd(16'h0010, 8);
    wait_dones(b_done + (PEND ? 2 : 1), 300);
    repeat (30) @(negedge clock);
    #1;
    chk("t5_flits", 32'(hs_cnt - b_hs), PEND ? 32'd24 : 32'd16);
    chk("t5_dones", 32'(done_cnt - b_done), PEND ? 32'd2 : 32'd1);
    chk("t5_errs", 32'(err_cnt - b_err), PEND ? 32'd0 : 32'd1);
    chk("t5_busy_rises", 32'(st_rise - b_rise), 32'd1);
    settle();

    // Reset in the middle of a transfer
    snap();
    expect_cmd(16'h0000, 16);
    send_cmd(16'h0000, 16);
    wait_hs(b_hs + 5, 100);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    exp_flit.delete();
    exp_addr.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1 chk_reset_vals("midrst_rel");
    snap();
    expect_cmd(16'h0020, 6);
    send_cmd(16'h0020, 6);
    wait_dones(b_done + 1, 100);
    chk("t6_flits", 32'(hs_cnt - b_hs), 32'd6);
    settle();

    // Random commands with random credit
    cmode = 2;
    for (int t = 0; t < 8; t++) begin
      logic [AW-1:0] a;
      int n;
      a = AW'($urandom);
      n = (t == 0) ? 1 : int'($urandom_range(1, 24));
      snap();
      expect_cmd(a, n);
      send_cmd(a, n);
      wait_dones(b_done + 1, 600);
      chk("rnd_flits", 32'(hs_cnt - b_hs), 32'(n));
      settle();
    end
    cmode = 0;

    chk("extra_reads", 32'(extra_rd), 32'd0);
    chk("extra_flits", 32'(extra_flit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddma_flit_sender.md
# ddma_flit_sender

Read-side DDMA engine for a processing element. It accepts a transfer command (start address, flit count, start pulse), reads the packet words from local memory and streams them as flits into the local router port. The memory image it reads is a header flit, then a size flit, then the payload, so the engine forwards words verbatim. It sits between the PE memory read port and the router local input, opposite the DDMA command/memory-fill driver side.

## Interface
- MEMORY_BUS_WIDTH, 32, memory read data width; must equal FLIT_WIDTH.
- FLIT_WIDTH, 32, router flit width.
- ADDR_WIDTH, 16, memory word-address width.
- COUNT_WIDTH, 16, width of the transfer length field.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2).

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_in  in  1  start pulse; sampled each rising edge.
- addr_in  in  ADDR_WIDTH  start word address, valid with cmd_in.
- nbytes_in  in  COUNT_WIDTH  number of flits to send (header + size + payload words), valid with cmd_in.
- status_out  out  1  busy.
- done_out  out  1  one-cycle completion pulse.
- err_out  out  1  one-cycle pulse: command dropped.
- mem_enable_out  out  1  memory read strobe.
- mem_addr_out  out  ADDR_WIDTH  memory read word address.
- mem_data_in  in  MEMORY_BUS_WIDTH  read data, valid exactly 1 cycle after strobe.
- tx_out  out  1  flit valid to router.
- data_out  out  FLIT_WIDTH  flit to router.
- credit_in  in  1  router accepts flit this cycle; transfer = tx_out && credit_in.

## Operation
- FSM: IDLE, FETCH, DRAIN, DONE.
- IDLE: cmd_in=1 latches base=addr_in, remaining=nbytes_in, sent=0. Go to DONE if nbytes_in==0, else FETCH.
- FETCH: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH. The read uses mem_addr_out=base+issued, modulo 2^ADDR_WIDTH, so the address wraps silently. Decrement remaining per read. Go to DRAIN when the last read is issued.
- Read data is pushed into the FIFO the cycle it returns. Push is unconditional; the space check guarantees room.
- DRAIN: wait until all inflight reads have returned and the FIFO is empty after the last handshake. Then go to DONE.
- DONE: done_out=1 for one cycle, then IDLE. With the pending feature and a pending command, go directly to FETCH/DONE with that command.
- tx_out = FIFO non-empty; data_out = FIFO head. Pop on transfer. With credit_in=0, tx_out and data_out hold stable.
- cmd_in while status_out=1: err_out pulse next cycle, command discarded. See Configuration for the exception.
- Flits leave in address order, count exactly nbytes_in; no header/size interpretation.

## Timing
- Reset values: status_out=0, done_out=0, err_out=0, mem_enable_out=0, mem_addr_out=0, tx_out=0, data_out=0. FIFO empty, FSM IDLE, pending empty.
- Reset mid-transfer aborts immediately. Inflight read data arriving after reset is ignored.
- cmd_in sampled at edge T:
  - status_out=1 from cycle T+1.
  - First mem_enable_out in cycle T+1 with addr_in.
  - First tx_out in cycle T+2.
- With credit_in held 1 and FIFO_DEPTH>=3, one flit per cycle. An N-flit transfer's last handshake occurs in cycle T+N+1, done_out in T+N+2, status_out=0 in T+N+3.
- Zero length: done_out in T+1, status_out high only in T+1, no memory reads, no tx_out.
- status_out stays high through the done_out cycle.
- cmd_in in the done_out cycle counts as busy.

## Configuration
- DDMA_CMD_PENDING_EN defined: one pending command register.
  - cmd_in while busy and pending empty is latched, with no err_out.
  - It starts the cycle after done_out; status_out stays 1 continuously.
  - cmd_in while busy and pending full: err_out pulse, dropped.
- Undefined: no pending register; every cmd_in while busy gives err_out.

## Test plan
- Memory[0..15] = header 0x00000101, size 14, payload; cmd addr=0 nbytes=16, credit_in=1 -> 16 flits in order, first tx_out at T+2, done_out at T+18.
- Same command with credit_in toggling 1-0 each cycle -> identical 16-flit sequence, data_out stable while credit_in=0, no FIFO overflow, done_out after 16th handshake.
- cmd nbytes=0 -> done_out at T+1, no mem_enable_out, no tx_out.
- addr=0xFFFE nbytes=4 (ADDR_WIDTH=16) -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Second cmd (addr=0x10, nbytes=8) issued during a 16-flit transfer:
  - Macro off: err_out pulse, only 16 flits sent.
  - Macro on: 24 flits, status_out never drops, one done_out per command.
- Reset asserted after 5 flits of a 16-flit transfer -> all outputs at reset values next cycle; new cmd then transfers cleanly from its own address.
